sio_dmu_out_sched: RTL and testbench

Outbound scheduler in the SIU that owns the SIU→DMU header/payload bus. It arbitrates round-robin between two outbound sources, such as DMA read-return queues, and checks that the DMU has a credit before issuing anything. For each granted packet it drives one header cycle and, when the packet carries data, four 128-bit payload beats with per-lane parity. It is the sole driver of `sio_dmu_hdr_vld`, `sio_dmu_datareq`, `sio_dmu_data` and `sio_dmu_parity`.

---
 rtl/sio_dmu_out_sched.sv | 186 ++++++++++++++++++
 tb/tb_sio_dmu_out_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sio_dmu_out_sched.sv
// sio_dmu_out_sched: outbound scheduler that owns the SIU->DMU header/payload bus.
// It arbitrates round-robin between NREQ requesters and issues only when the DMU has a
// header credit. Each packet is one header cycle plus, for data packets, a turnaround
// cycle and four 128-bit payload beats.
//
// Ports:
//   iol2clk_i              clock, all logic on the rising edge
//   rst_i                  synchronous active-high reset
//   req_vld_i/req_hdr_i    per-requester packet pending and its 128-bit header
//   req_has_data_i         packet carries a 4-beat payload
//   req_ack_o              one-cycle ack, coincident with the header cycle
//   pld_pop_o/pld_data_i   show-ahead payload pop and beat, per requester
//   dmu_sio_credit_ret_i   DMU returns one header credit
//   sio_dmu_hdr_vld_o      header cycle
//   sio_dmu_datareq_o      header cycle of a packet with payload
//   sio_dmu_data_o         header or payload beat, 0 otherwise
//   sio_dmu_parity_o       even parity per 16-bit lane of sio_dmu_data_o
//   credit_cnt_o           credits available
//   credit_ovf_o           sticky: credit returned while already full
//   busy_o                 scheduler not idle
module sio_dmu_out_sched #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned CREDITS = 4
) (
   input  logic                iol2clk_i,
   input  logic                rst_i,
   input  logic [NREQ-1:0]     req_vld_i,
   input  logic [NREQ*128-1:0] req_hdr_i,
   input  logic [NREQ-1:0]     req_has_data_i,
   output logic [NREQ-1:0]     req_ack_o,
   output logic [NREQ-1:0]     pld_pop_o,
   input  logic [NREQ*128-1:0] pld_data_i,
   input  logic                dmu_sio_credit_ret_i,
   output logic                sio_dmu_hdr_vld_o,
   output logic                sio_dmu_datareq_o,
   output logic [127:0]        sio_dmu_data_o,
   output logic [7:0]          sio_dmu_parity_o,
   output logic [2:0]          credit_cnt_o,
   output logic                credit_ovf_o,
   output logic                busy_o
);

   localparam int unsigned IdxW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [2:0]  CredMax = 3'(CREDITS);

   typedef enum logic [1:0] {StIdle, StHdr, StGap, StPld} state_e;

   state_e          state_q, state_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [IdxW-1:0] last_q, last_d;   // last winner; also owner of the packet in flight
   logic [2:0]      credit_q, credit_d;
   logic            ovf_q, ovf_d;
   logic            hdr_vld_q, hdr_vld_d;
   logic            datareq_q, datareq_d;
   logic [127:0]    data_q, data_d;
   logic [7:0]      parity_q, parity_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] pop;

   logic [127:0]    hdr_a [NREQ];
   logic [127:0]    pld_a [NREQ];
   logic [IdxW-1:0] win, cand;
   logic            win_vld, arb_slot, grant;

   for (genvar r = 0; r < NREQ; r++) begin : g_unpack
      assign hdr_a[r] = req_hdr_i[128*r +: 128];
      assign pld_a[r] = pld_data_i[128*r +: 128];
   end

   // Round-robin: first valid requester after the last winner.
   always_comb begin
      win     = last_q;
      win_vld = 1'b0;
      cand    = last_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = cand + IdxW'(1);
         if (!win_vld && req_vld_i[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      last_d    = last_q;
      data_d    = '0;
      hdr_vld_d = 1'b0;
      datareq_d = 1'b0;
      ack_d     = '0;
      pop       = '0;
      parity_d  = '0;

      case (state_q)
         StIdle: state_d = StIdle;
         StHdr:  state_d = datareq_q ? StGap : StIdle;
         StGap: begin
            pop[last_q] = 1'b1;
            data_d      = pld_a[last_q];
            bcnt_d      = '0;
            state_d     = StPld;
         end
         StPld: begin
            if (bcnt_q != 2'd3) begin
               pop[last_q] = 1'b1;
               data_d      = pld_a[last_q];
               bcnt_d      = bcnt_q + 2'd1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // The last payload cycle also arbitrates, so a header can follow the final
      // beat directly and data headers stay six cycles apart.
      arb_slot = (state_q == StIdle) || ((state_q == StPld) && (bcnt_q == 2'd3));
      grant    = arb_slot && win_vld && (credit_q != '0);

      if (grant) begin
         data_d     = hdr_a[win];
         hdr_vld_d  = 1'b1;
         datareq_d  = req_has_data_i[win];
         ack_d[win] = 1'b1;
         last_d     = win;
         state_d    = StHdr;
      end

      for (int i = 0; i < 8; i++) begin
         parity_d[i] = ^data_d[16*i +: 16];
      end
   end

   // Credit accounting: +return -consume; a return while full saturates and flags.
   always_comb begin
      credit_d = credit_q;
      ovf_d    = ovf_q;
      if (dmu_sio_credit_ret_i && !grant) begin
         if (credit_q >= CredMax) begin
            ovf_d = 1'b1;
         end else begin
            credit_d = credit_q + 3'd1;
         end
      end else if (!dmu_sio_credit_ret_i && grant) begin
         credit_d = credit_q - 3'd1;
      end
   end

   always_ff @(posedge iol2clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         bcnt_q    <= '0;
         last_q    <= IdxW'(NREQ - 1);
         credit_q  <= CredMax;
         ovf_q     <= 1'b0;
         hdr_vld_q <= 1'b0;
         datareq_q <= 1'b0;
         data_q    <= '0;
         parity_q  <= '0;
         ack_q     <= '0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         last_q    <= last_d;
         credit_q  <= credit_d;
         ovf_q     <= ovf_d;
         hdr_vld_q <= hdr_vld_d;
         datareq_q <= datareq_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         ack_q     <= ack_d;
      end
   end

   assign req_ack_o         = ack_q;
   assign pld_pop_o         = pop;
   assign sio_dmu_hdr_vld_o = hdr_vld_q;
   assign sio_dmu_datareq_o = datareq_q;
   assign sio_dmu_data_o    = data_q;
   assign sio_dmu_parity_o  = parity_q;
   assign credit_cnt_o      = credit_q;
   assign credit_ovf_o      = ovf_q;
   assign busy_o            = (state_q != StIdle);

endmodule

// File: tb/tb_sio_dmu_out_sched.sv
// tb_sio_dmu_out_sched: self-checking bench for sio_dmu_out_sched. Directed scenarios
// plus a randomized two-requester stream checked against a transaction-level model
// that predicts bus contents cycle by cycle from arbitration order, credits and the
// header/payload timing rules.
module tb_sio_dmu_out_sched;

   localparam int RN = 300;

   logic         iol2clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   req_vld = '0;
   logic [1:0]   req_has_data = '0;
   logic [255:0] req_hdr = '0;
   logic [255:0] pld_data = '0;
   logic         credit_ret = 1'b0;
   logic [1:0]   req_ack, pld_pop;
   logic         hdr_vld, datareq, credit_ovf, busy;
   logic [127:0] data;
   logic [7:0]   parity;
   logic [2:0]   credit_cnt;

   int n_pass = 0;
   int n_total = 0;

   logic [127:0] e_data [RN+8];
   logic         e_hv   [RN+8];
   logic         e_dr   [RN+8];
   logic [1:0]   e_ack  [RN+8];
   logic [1:0]   e_pop  [RN+8];
   logic         e_busy [RN+8];

   sio_dmu_out_sched #(.NREQ(2), .CREDITS(4)) dut (
      .iol2clk_i           (iol2clk),
      .rst_i               (rst),
      .req_vld_i           (req_vld),
      .req_hdr_i           (req_hdr),
      .req_has_data_i      (req_has_data),
      .req_ack_o           (req_ack),
      .pld_pop_o           (pld_pop),
      .pld_data_i          (pld_data),
      .dmu_sio_credit_ret_i(credit_ret),
      .sio_dmu_hdr_vld_o   (hdr_vld),
      .sio_dmu_datareq_o   (datareq),
      .sio_dmu_data_o      (data),
      .sio_dmu_parity_o    (parity),
      .credit_cnt_o        (credit_cnt),
      .credit_ovf_o        (credit_ovf),
      .busy_o              (busy)
   );

   always #5 iol2clk = ~iol2clk;

   wire [146:0] obs = {hdr_vld, datareq, data, parity, req_ack, pld_pop, busy, credit_cnt,
                       credit_ovf};

   function automatic logic [7:0] lane_par(input logic [127:0] d);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
      return p;
   endfunction

   function automatic logic [146:0] ev(input logic hv, input logic dr, input logic [127:0] d,
                                       input logic [1:0] ack, input logic [1:0] pop,
                                       input logic bsy, input logic [2:0] cred,
                                       input logic ovf);
      return {hv, dr, d, lane_par(d), ack, pop, bsy, cred, ovf};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge iol2clk);
      #1;
   endtask

   task automatic apply_reset();
      rst          = 1'b1;
      req_vld      = '0;
      req_has_data = '0;
      credit_ret   = 1'b0;
      pld_data     = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [146:0] e;
      rst          = 1'b1;
      req_vld      = 2'b11;
      req_has_data = 2'b11;
      req_hdr      = {rnd128(), rnd128()};
      credit_ret   = 1'b1;
      e            = ev(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd4, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++;
         if (obs !== e) $display("FAIL reset_hold %0d: got %h exp %h", i, obs, e);
         else n_pass++;
      end
      rst        = 1'b0;
      req_vld    = '0;
      credit_ret = 1'b0;
      tick();
      n_total++;
      if (obs !== e) $display("FAIL reset_release: got %h exp %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_single_dataless();
      logic [146:0] e;
      apply_reset();
      req_vld      = 2'b01;
      req_hdr      = {128'h0, 128'hA5};
      req_has_data = 2'b00;
      tick();
      e = ev(1'b1, 1'b0, 128'hA5, 2'b01, 2'b00, 1'b1, 3'd3, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL single_hdr: got %h exp %h", obs, e);
      else n_pass++;
      n_total++;
      if (parity !== 8'h00) $display("FAIL single_parity: got %h exp 00", parity);
      else n_pass++;
      req_vld = '0;
      tick();
      e = ev(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd3, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL single_after: got %h exp %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_data_packet();
      logic [127:0] beats [4];
      logic [127:0] hdr, ed;
      logic [146:0] e;
      logic [1:0]   p;
      int           k;
      apply_reset();
      for (int i = 0; i < 4; i++) beats[i] = 128'(i + 1);
      hdr          = rnd128();
      k            = 0;
      req_vld      = 2'b10;
      req_hdr      = {hdr, 128'h0};
      req_has_data = 2'b10;
      pld_data     = {beats[0], 128'h0};
      tick();
      req_vld = '0;
      for (int off = 0; off <= 6; off++) begin
         ed = (off == 0) ? hdr : ((off >= 2 && off <= 5) ? beats[off-2] : 128'h0);
         e  = ev(off == 0, off == 0, ed, (off == 0) ? 2'b10 : 2'b00,
                 (off >= 1 && off <= 4) ? 2'b10 : 2'b00, off <= 5, 3'd3, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL data_pkt H+%0d: got %h exp %h", off, obs, e);
         else n_pass++;
         p = pld_pop;
         tick();
         if (p[1]) k++;
         pld_data = {(k < 4) ? beats[k] : 128'h0, 128'h0};
      end
      n_total++;
      if (k !== 4) $display("FAIL data_pop_count: got %0d exp 4", k);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int           n [2];
      int           j, w;
      logic [146:0] e;
      logic [1:0]   a;
      apply_reset();
      n            = '{0, 0};
      req_vld      = 2'b11;
      req_has_data = 2'b00;
      req_hdr      = {64'd2, 64'd0, 64'd1, 64'd0};
      for (int off = 0; off <= 16; off++) begin
         j = (off - 1) / 2;
         w = j % 2;
         if (off % 2 == 1)
            e = ev(1'b1, 1'b0, {64'(w + 1), 64'(j / 2)}, (w == 0) ? 2'b01 : 2'b10, 2'b00,
                   1'b1, 3'd3, 1'b0);
         else
            e = ev(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd4, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL rr cyc %0d: got %h exp %h", off, obs, e);
         else n_pass++;
         a          = req_ack;
         credit_ret = (off % 2 == 1);
         tick();
         for (int r = 0; r < 2; r++) if (a[r]) n[r]++;
         req_hdr = {64'd2, 64'(n[1]), 64'd1, 64'(n[0])};
      end
      req_vld    = '0;
      credit_ret = 1'b0;
   endtask

   task automatic test_credit_stall();
      int           cred_tab [19] = '{4, 3, 3, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
      int           hidx;
      logic         hv;
      logic [146:0] e;
      apply_reset();
      hidx         = 0;
      req_vld      = 2'b01;
      req_has_data = 2'b00;
      req_hdr      = {128'h0, 64'hC, 64'd0};
      for (int off = 0; off <= 18; off++) begin
         hv = (off inside {1, 3, 5, 7, 14, 18});
         e  = ev(hv, 1'b0, hv ? {64'hC, 64'(hidx)} : 128'h0, hv ? 2'b01 : 2'b00, 2'b00, hv,
                 3'(cred_tab[off]), 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL credit_stall cyc %0d: got %h exp %h", off, obs, e);
         else n_pass++;
         credit_ret = (off inside {12, 16, 17});
         tick();
         if (hv) hidx++;
         req_hdr = {128'h0, 64'hC, 64'(hidx)};
      end
      req_vld    = '0;
      credit_ret = 1'b0;
   endtask

   task automatic test_credit_ovf();
      logic [146:0] e;
      logic [127:0] h;
      apply_reset();
      credit_ret = 1'b1;
      tick();
      credit_ret = 1'b0;
      e = ev(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd4, 1'b1);
      n_total++;
      if (obs !== e) $display("FAIL ovf_set: got %h exp %h", obs, e);
      else n_pass++;
      repeat (3) tick();
      n_total++;
      if (obs !== e) $display("FAIL ovf_sticky: got %h exp %h", obs, e);
      else n_pass++;
      h            = rnd128();
      req_vld      = 2'b01;
      req_has_data = 2'b00;
      req_hdr      = {128'h0, h};
      tick();
      req_vld = '0;
      e = ev(1'b1, 1'b0, h, 2'b01, 2'b00, 1'b1, 3'd3, 1'b1);
      n_total++;
      if (obs !== e) $display("FAIL ovf_after_hdr: got %h exp %h", obs, e);
      else n_pass++;
      apply_reset();
      e = ev(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd4, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL ovf_cleared: got %h exp %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_reset_mid_packet();
      logic [127:0] h0, bt;
      logic [146:0] e;
      apply_reset();
      h0           = rnd128();
      bt           = rnd128();
      req_vld      = 2'b01;
      req_has_data = 2'b01;
      req_hdr      = {128'h0, h0};
      pld_data     = {128'h0, bt};
      tick();
      req_vld = '0;
      repeat (3) tick();
      e = ev(1'b0, 1'b0, bt, 2'b00, 2'b01, 1'b1, 3'd3, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL midrst_H3: got %h exp %h", obs, e);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      e = ev(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd4, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL midrst_reset: got %h exp %h", obs, e);
      else n_pass++;
      req_vld      = 2'b11;
      req_has_data = 2'b00;
      req_hdr      = {~h0, h0};
      tick();
      req_vld = '0;
      e = ev(1'b1, 1'b0, h0, 2'b01, 2'b00, 1'b1, 3'd3, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL midrst_rr_restart: got %h exp %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [127:0] cur_hdr [2];
      logic         cur_hd  [2];
      logic [127:0] cur_bt  [2][4];
      logic [127:0] pq0[$];
      logic [127:0] pq1[$];
      logic [1:0]   hold, a, p;
      logic         ret;
      logic [146:0] e;
      int           credit, cnext, next_ok, lg, w;
      apply_reset();
      for (int i = 0; i < RN + 8; i++) begin
         e_hv[i] = 1'b0; e_dr[i] = 1'b0; e_data[i] = '0;
         e_ack[i] = '0; e_pop[i] = '0; e_busy[i] = 1'b0;
      end
      for (int r = 0; r < 2; r++) begin
         cur_hdr[r] = '0;
         cur_hd[r]  = 1'b0;
      end
      hold    = '0;
      credit  = 4;
      next_ok = 0;
      lg      = 1;
      for (int c = 0; c < RN; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (!hold[r] && $urandom_range(0, 2) != 0) begin
               hold[r]    = 1'b1;
               cur_hdr[r] = rnd128();
               cur_hd[r]  = 1'($urandom_range(0, 1));
               for (int k = 0; k < 4; k++) cur_bt[r][k] = rnd128();
            end
         end
         req_vld      = hold;
         req_hdr      = {cur_hdr[1], cur_hdr[0]};
         req_has_data = {cur_hd[1], cur_hd[0]};
         pld_data     = {(pq1.size() > 0) ? pq1[0] : 128'h0, (pq0.size() > 0) ? pq0[0] : 128'h0};
         ret          = (credit < 4) && ($urandom_range(0, 3) == 0);
         credit_ret   = ret;
         e = ev(e_hv[c], e_dr[c], e_data[c], e_ack[c], e_pop[c], e_busy[c], 3'(credit), 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL random cyc %0d: got %h exp %h", c, obs, e);
         else n_pass++;
         // Model: bus free, something pending and a credit in hand -> header next cycle.
         cnext = credit + int'(ret);
         if (c + 1 >= next_ok && hold != '0 && credit > 0) begin
            w = hold[(lg + 1) % 2] ? (lg + 1) % 2 : lg;
            e_hv[c+1]      = 1'b1;
            e_dr[c+1]      = cur_hd[w];
            e_data[c+1]    = cur_hdr[w];
            e_ack[c+1][w]  = 1'b1;
            e_busy[c+1]    = 1'b1;
            if (cur_hd[w]) begin
               for (int k = 1; k <= 4; k++) e_pop[c+1+k][w] = 1'b1;
               for (int k = 0; k < 4; k++) e_data[c+3+k] = cur_bt[w][k];
               for (int k = 1; k <= 5; k++) e_busy[c+1+k] = 1'b1;
               next_ok = c + 7;
            end else begin
               next_ok = c + 3;
            end
            cnext--;
            lg = w;
         end
         a = req_ack;
         p = pld_pop;
         tick();
         if (p[0] && pq0.size() > 0) void'(pq0.pop_front());
         if (p[1] && pq1.size() > 0) void'(pq1.pop_front());
         for (int r = 0; r < 2; r++) begin
            if (a[r]) begin
               hold[r] = 1'b0;
               if (cur_hd[r]) begin
                  for (int k = 0; k < 4; k++) begin
                     if (r == 0) pq0.push_back(cur_bt[0][k]);
                     else pq1.push_back(cur_bt[1][k]);
                  end
               end
            end
         end
         credit = cnext;
      end
      req_vld    = '0;
      credit_ret = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_dataless();
      test_data_packet();
      test_round_robin();
      test_credit_stall();
      test_credit_ovf();
      test_reset_mid_packet();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
